// File: rtl/spi_target.sv
// -----------------------------------------------------------------------------
// spi_target
//   SPI target (slave), mode 0 (CPOL=0, CPHA=0), MSB first. The SPI pins are
//   asynchronous to i_Clk. Each pin goes through a two-flop synchronizer, and
//   an extra history flop provides edge detection. The block receives
//   RX_WIDTH-bit frames on MOSI. It sends a TX_WIDTH-bit response on MISO,
//   which is loaded from a single-entry pending buffer when a frame starts.
//
// Ports
//   i_Clk          system clock, rising edge; must run >= 4x SCK
//   i_Rst_L        asynchronous active-low reset
//   i_SPI_Clk      SPI clock from master
//   i_SPI_CS_n     chip select, active low
//   i_SPI_MOSI     serial data in, MSB first
//   o_SPI_MISO     serial data out, MSB first
//   o_SPI_MISO_En  MISO output enable (frame active)
//   o_RX_Word      last complete received frame
//   o_RX_DV        one-cycle pulse when o_RX_Word updates
//   i_TX_Byte      response byte for the next frame
//   i_TX_DV        load strobe for i_TX_Byte (only when o_TX_Ready)
//   o_TX_Ready     no response byte pending
//   o_Frame_Err    one-cycle pulse: CS_n rose mid-frame
//   o_Overrun      one-cycle pulse: extra SCK rising edge after a full frame
// -----------------------------------------------------------------------------
module spi_target #(
    parameter int RX_WIDTH = 16,
    parameter int TX_WIDTH = 8
) (
    input  logic                i_Clk,
    input  logic                i_Rst_L,
    input  logic                i_SPI_Clk,
    input  logic                i_SPI_CS_n,
    input  logic                i_SPI_MOSI,
    output logic                o_SPI_MISO,
    output logic                o_SPI_MISO_En,
    output logic [RX_WIDTH-1:0] o_RX_Word,
    output logic                o_RX_DV,
    input  logic [TX_WIDTH-1:0] i_TX_Byte,
    input  logic                i_TX_DV,
    output logic                o_TX_Ready,
    output logic                o_Frame_Err,
    output logic                o_Overrun
);

    localparam int CNT_W = $clog2(RX_WIDTH + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_HOLD
    } state_e;

    // Synchronizers: [0] and [1] are the two metastability flops, and [2]
    // holds the previous synchronized value for edge detection.
    logic [2:0] sck_sync_q;
    logic [2:0] cs_sync_q;
    logic [1:0] mosi_sync_q;

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the values from before the clock edge.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            sck_sync_q  <= '0;
            // CS_n history resets low. This way, a CS_n that is already low
            // when reset is released does not look like a falling edge and
            // does not start a frame. A high CS_n only produces a rising edge,
            // and that edge is ignored in IDLE.
            cs_sync_q   <= '0;
            mosi_sync_q <= '0;
        end else begin
            sck_sync_q  <= {sck_sync_q[1:0], i_SPI_Clk};
            cs_sync_q   <= {cs_sync_q[1:0], i_SPI_CS_n};
            mosi_sync_q <= {mosi_sync_q[0], i_SPI_MOSI};
        end
    end

    logic sck_rise, sck_fall, cs_fall, cs_rise, mosi_bit;
    assign sck_rise = sck_sync_q[1] & ~sck_sync_q[2];
    assign sck_fall = ~sck_sync_q[1] & sck_sync_q[2];
    assign cs_rise  = cs_sync_q[1] & ~cs_sync_q[2];
    assign cs_fall  = ~cs_sync_q[1] & cs_sync_q[2];
    assign mosi_bit = mosi_sync_q[1];

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [RX_WIDTH-1:0] rx_sr_q, rx_sr_d;
    logic [RX_WIDTH-1:0] rx_word_q, rx_word_d;
    logic [TX_WIDTH-1:0] tx_sr_q, tx_sr_d;
    logic [TX_WIDTH-1:0] pend_byte_q, pend_byte_d;
    logic                pend_q, pend_d;
    logic                rx_dv_q, rx_dv_d;
    logic                frame_err_q, frame_err_d;
    logic                overrun_q, overrun_d;

    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path
        // can leave one unassigned and infer a latch.
        state_d     = state_q;
        cnt_d       = cnt_q;
        rx_sr_d     = rx_sr_q;
        rx_word_d   = rx_word_q;
        tx_sr_d     = tx_sr_q;
        pend_d      = pend_q;
        pend_byte_d = pend_byte_q;
        rx_dv_d     = 1'b0;
        frame_err_d = 1'b0;
        overrun_d   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (cs_fall) begin
                    state_d = ST_SHIFT;
                    cnt_d   = '0;
                    rx_sr_d = '0;
                    tx_sr_d = pend_q ? pend_byte_q : '0;
                    pend_d  = 1'b0;
                end
            end
            ST_SHIFT: begin
                if (sck_rise) begin
                    rx_sr_d = {rx_sr_q[RX_WIDTH-2:0], mosi_bit};
                    cnt_d   = cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(RX_WIDTH - 1)) begin
                        rx_word_d = rx_sr_d;
                        rx_dv_d   = 1'b1;
                        state_d   = ST_HOLD;
                    end
                end
                if (sck_fall) begin
                    tx_sr_d = tx_sr_q << 1;
                end
                // When the final SCK edge and CS_n release land in the same
                // cycle, the completed frame wins: no error is flagged, but
                // the FSM still returns to IDLE.
                if (cs_rise) begin
                    state_d = ST_IDLE;
                    if (!rx_dv_d && cnt_d != '0) begin
                        frame_err_d = 1'b1;
                    end
                end
            end
            ST_HOLD: begin
                if (sck_rise) begin
                    overrun_d = 1'b1;
                end
                if (cs_rise) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // This acceptance check runs after the frame-start clear above. A
        // strobe in the same cycle as the load therefore becomes the next
        // pending byte, but only if the buffer was empty going in.
        if (i_TX_DV && !pend_q) begin
            pend_d      = 1'b1;
            pend_byte_d = i_TX_Byte;
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            rx_sr_q     <= '0;
            rx_word_q   <= '0;
            tx_sr_q     <= '0;
            pend_q      <= 1'b0;
            pend_byte_q <= '0;
            rx_dv_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rx_sr_q     <= rx_sr_d;
            rx_word_q   <= rx_word_d;
            tx_sr_q     <= tx_sr_d;
            pend_q      <= pend_d;
            pend_byte_q <= pend_byte_d;
            rx_dv_q     <= rx_dv_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    // The left shift fills with zeros, so MISO drops to 0 after TX_WIDTH bits.
    assign o_SPI_MISO    = (state_q == ST_SHIFT) & tx_sr_q[TX_WIDTH-1];
    assign o_SPI_MISO_En = (state_q != ST_IDLE);
    assign o_RX_Word     = rx_word_q;
    assign o_RX_DV       = rx_dv_q;
    assign o_TX_Ready    = ~pend_q;
    assign o_Frame_Err   = frame_err_q;
    assign o_Overrun     = overrun_q;

endmodule

// File: tb/tb_spi_target.sv
// -----------------------------------------------------------------------------
// tb_spi_target
//   Directed, table-driven bench for spi_target (RX_WIDTH=16, TX_WIDTH=8).
//   Each table entry describes one SPI frame and the results expected from it.
//   Hand-written sequences cover TX buffer blocking and reset in mid-frame.
// -----------------------------------------------------------------------------
module tb_spi_target;

    logic        i_Clk;
    logic        i_Rst_L;
    logic        i_SPI_Clk;
    logic        i_SPI_CS_n;
    logic        i_SPI_MOSI;
    logic        o_SPI_MISO;
    logic        o_SPI_MISO_En;
    logic [15:0] o_RX_Word;
    logic        o_RX_DV;
    logic [7:0]  i_TX_Byte;
    logic        i_TX_DV;
    logic        o_TX_Ready;
    logic        o_Frame_Err;
    logic        o_Overrun;

    spi_target #(.RX_WIDTH(16), .TX_WIDTH(8)) dut (
        .i_Clk        (i_Clk),
        .i_Rst_L      (i_Rst_L),
        .i_SPI_Clk    (i_SPI_Clk),
        .i_SPI_CS_n   (i_SPI_CS_n),
        .i_SPI_MOSI   (i_SPI_MOSI),
        .o_SPI_MISO   (o_SPI_MISO),
        .o_SPI_MISO_En(o_SPI_MISO_En),
        .o_RX_Word    (o_RX_Word),
        .o_RX_DV      (o_RX_DV),
        .i_TX_Byte    (i_TX_Byte),
        .i_TX_DV      (i_TX_DV),
        .o_TX_Ready   (o_TX_Ready),
        .o_Frame_Err  (o_Frame_Err),
        .o_Overrun    (o_Overrun)
    );

    // i_Clk period 10; the SCK half period is 50, giving a 10x ratio.
    initial begin
        i_Clk = 1'b0;
        forever #5 i_Clk = ~i_Clk;
    end

    // Pulse monitors sample on the falling edge, away from the active edge.
    int  dv_cnt;
    int  err_cnt;
    int  ovr_cnt;
    time dv_t;
    always @(negedge i_Clk) begin
        if (o_RX_DV) begin
            dv_cnt = dv_cnt + 1;
            dv_t   = $time;
        end
        if (o_Frame_Err) err_cnt = err_cnt + 1;
        if (o_Overrun)   ovr_cnt = ovr_cnt + 1;
    end

    int n_vec;
    int n_miss;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec = n_vec + 1;
        if (act !== exp) begin
            n_miss = n_miss + 1;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    logic [15:0] miso_cap;
    time         rise_t;

    task automatic load_byte(input logic [7:0] b);
        @(posedge i_Clk);
        #1;
        i_TX_Byte = b;
        i_TX_DV   = 1'b1;
        @(posedge i_Clk);
        #1;
        i_TX_DV = 1'b0;
        @(negedge i_Clk);
    endtask

    // Drive CS_n low on a known clock phase. The synchronized falling edge
    // is then seen in the cycle between the 2nd and 3rd rising edges, so an
    // optional TX strobe can be placed exactly on the frame-start load.
    task automatic cs_low(input logic sim_load, input logic [7:0] sim_byte);
        @(posedge i_Clk);
        #1;
        i_SPI_CS_n = 1'b0;
        @(posedge i_Clk);
        @(posedge i_Clk);
        #1;
        if (sim_load) begin
            i_TX_Byte = sim_byte;
            i_TX_DV   = 1'b1;
        end
        @(posedge i_Clk);
        #1;
        i_TX_DV = 1'b0;
        #70;
    endtask

    // Mode-0 master: MOSI changes while SCK is low, and MISO is sampled just
    // before each rising edge. The first 16 sampled MISO bits are kept.
    task automatic send_bits(input logic [31:0] data, input int n, input logic cs_last);
        miso_cap = '0;
        for (int i = 0; i < n; i++) begin
            i_SPI_MOSI = data[n-1-i];
            #50;
            if (i < 16) miso_cap = {miso_cap[14:0], o_SPI_MISO};
            i_SPI_Clk = 1'b1;
            if (i == 15) rise_t = $time;
            if (cs_last && i == n - 1) i_SPI_CS_n = 1'b1;
            #50;
            i_SPI_Clk = 1'b0;
        end
    endtask

    task automatic cs_high();
        #100;
        i_SPI_CS_n = 1'b1;
        #200;
    endtask

    typedef struct {
        logic        pre_load;
        logic [7:0]  pre_byte;
        logic        sim_load;
        logic [7:0]  sim_byte;
        logic [31:0] data;
        int          nbits;
        logic        cs_last;
        logic [15:0] exp_word;
        int          exp_dv;
        int          exp_err;
        int          exp_ovr;
        logic [15:0] exp_miso;
        logic        exp_ready;
    } vec_t;

    vec_t vecs[10];

    initial begin
        int dv0, err0, ovr0;
        n_vec  = 0;
        n_miss = 0;

        //            pre  pbyte   sim  sbyte  data          n   csl  word      dv err ovr miso      rdy
        vecs[0] = '{1'b1, 8'hA5, 1'b0, 8'h00, 32'h0000C1A2, 16, 1'b0, 16'hC1A2, 1, 0, 0, 16'hA500, 1'b1};
        vecs[1] = '{1'b0, 8'h00, 1'b0, 8'h00, 32'h0000C1A2, 16, 1'b0, 16'hC1A2, 1, 0, 0, 16'h0000, 1'b1};
        vecs[2] = '{1'b0, 8'h00, 1'b0, 8'h00, 32'h0000C1A3, 16, 1'b0, 16'hC1A3, 1, 0, 0, 16'h0000, 1'b1};
        vecs[3] = '{1'b0, 8'h00, 1'b0, 8'h00, 32'h00000055,  7, 1'b0, 16'hC1A3, 0, 1, 0, 16'h0000, 1'b1};
        vecs[4] = '{1'b1, 8'h5A, 1'b0, 8'h00, 32'h00002469, 17, 1'b0, 16'h1234, 1, 0, 1, 16'h5A00, 1'b1};
        vecs[5] = '{1'b0, 8'h00, 1'b0, 8'h00, 32'h0000BEEF, 16, 1'b1, 16'hBEEF, 1, 0, 0, 16'h0000, 1'b1};
        vecs[6] = '{1'b0, 8'h00, 1'b0, 8'h00, 32'h00000000,  0, 1'b0, 16'hBEEF, 0, 0, 0, 16'h0000, 1'b1};
        vecs[7] = '{1'b1, 8'hA5, 1'b1, 8'h77, 32'h00000F0F, 16, 1'b0, 16'h0F0F, 1, 0, 0, 16'hA500, 1'b1};
        vecs[8] = '{1'b0, 8'h00, 1'b1, 8'h66, 32'h0000F0F0, 16, 1'b0, 16'hF0F0, 1, 0, 0, 16'h0000, 1'b0};
        vecs[9] = '{1'b0, 8'h00, 1'b0, 8'h00, 32'h00000001, 16, 1'b0, 16'h0001, 1, 0, 0, 16'h6600, 1'b1};

        i_Rst_L    = 1'b0;
        i_SPI_Clk  = 1'b0;
        i_SPI_CS_n = 1'b1;
        i_SPI_MOSI = 1'b0;
        i_TX_Byte  = '0;
        i_TX_DV    = 1'b0;
        #23;
        check("reset word",  32'(o_RX_Word),     32'h0);
        check("reset dv",    32'(o_RX_DV),       32'h0);
        check("reset err",   32'(o_Frame_Err),   32'h0);
        check("reset ovr",   32'(o_Overrun),     32'h0);
        check("reset miso",  32'(o_SPI_MISO),    32'h0);
        check("reset en",    32'(o_SPI_MISO_En), 32'h0);
        check("reset ready", 32'(o_TX_Ready),    32'h1);
        i_Rst_L = 1'b1;
        #50;

        for (int v = 0; v < 10; v++) begin
            if (vecs[v].pre_load) begin
                load_byte(vecs[v].pre_byte);
                check($sformatf("v%0d ready after load", v), 32'(o_TX_Ready), 32'h0);
            end
            dv0  = dv_cnt;
            err0 = err_cnt;
            ovr0 = ovr_cnt;
            cs_low(vecs[v].sim_load, vecs[v].sim_byte);
            check($sformatf("v%0d en in frame", v), 32'(o_SPI_MISO_En), 32'h1);
            send_bits(vecs[v].data, vecs[v].nbits, vecs[v].cs_last);
            cs_high();
            check($sformatf("v%0d word", v), 32'(o_RX_Word), 32'(vecs[v].exp_word));
            check($sformatf("v%0d dv pulses", v), 32'(dv_cnt - dv0), 32'(vecs[v].exp_dv));
            check($sformatf("v%0d err pulses", v), 32'(err_cnt - err0), 32'(vecs[v].exp_err));
            check($sformatf("v%0d ovr pulses", v), 32'(ovr_cnt - ovr0), 32'(vecs[v].exp_ovr));
            check($sformatf("v%0d ready", v), 32'(o_TX_Ready), 32'(vecs[v].exp_ready));
            check($sformatf("v%0d en idle", v), 32'(o_SPI_MISO_En), 32'h0);
            if (vecs[v].nbits >= 16) begin
                check($sformatf("v%0d miso", v), 32'(miso_cap), 32'(vecs[v].exp_miso));
                check($sformatf("v%0d dv latency ok", v), 32'((dv_t - rise_t) <= 45), 32'h1);
            end
        end

        // Strobe while a byte is pending is ignored.
        load_byte(8'h3C);
        load_byte(8'hFF);
        check("blocked ready", 32'(o_TX_Ready), 32'h0);
        cs_low(1'b0, 8'h00);
        check("blocked ready at start", 32'(o_TX_Ready), 32'h1);
        send_bits(32'h00001357, 16, 1'b0);
        cs_high();
        check("blocked miso", 32'(miso_cap), 32'h3C00);
        check("blocked word", 32'(o_RX_Word), 32'h1357);

        // Reset during a frame discards the frame and the pending byte. CS_n
        // still low at release must not start a frame.
        load_byte(8'h99);
        dv0  = dv_cnt;
        err0 = err_cnt;
        ovr0 = ovr_cnt;
        cs_low(1'b0, 8'h00);
        send_bits(32'h00000183, 9, 1'b0);
        i_Rst_L = 1'b0;
        #30;
        check("mid reset word",  32'(o_RX_Word),     32'h0);
        check("mid reset en",    32'(o_SPI_MISO_En), 32'h0);
        check("mid reset ready", 32'(o_TX_Ready),    32'h1);
        i_Rst_L = 1'b1;
        #100;
        check("cs held low no frame", 32'(o_SPI_MISO_En), 32'h0);
        i_SPI_CS_n = 1'b1;
        #100;
        cs_low(1'b0, 8'h00);
        send_bits(32'h0000C1A3, 16, 1'b0);
        cs_high();
        check("post reset word", 32'(o_RX_Word),      32'hC1A3);
        check("post reset dv",   32'(dv_cnt - dv0),   32'h1);
        check("post reset err",  32'(err_cnt - err0), 32'h0);
        check("post reset ovr",  32'(ovr_cnt - ovr0), 32'h0);
        check("post reset miso", 32'(miso_cap),       32'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/spi_target.md
SPI_TARGET -- requirements
Module: spi_target

Interface
REQ-001 Parameter RX_WIDTH, default 16: bits per received MOSI frame.
REQ-002 Parameter TX_WIDTH, default 8: bits per transmitted MISO response.
REQ-003 i_Clk  input  1  system clock; all logic on rising edge.
REQ-004 i_Rst_L  input  1  reset, asynchronous assert, active-low.
REQ-005 i_SPI_Clk  input  1  SPI clock from master, mode 0 (CPOL=0, CPHA=0), asynchronous to i_Clk.
REQ-006 i_SPI_CS_n  input  1  chip select, active-low, frames a transaction.
REQ-007 i_SPI_MOSI  input  1  serial data from master, MSB first.
REQ-008 o_SPI_MISO  output  1  serial data to master, MSB first.
REQ-009 o_SPI_MISO_En  output  1  MISO output enable; 1 only while CS_n synchronized low.
REQ-010 o_RX_Word  output  RX_WIDTH  last complete received frame.
REQ-011 o_RX_DV  output  1  one-cycle pulse: o_RX_Word updated.
REQ-012 i_TX_Byte  input  TX_WIDTH  response byte to send in next frame.
REQ-013 i_TX_DV  input  1  load strobe for i_TX_Byte, honoured only when o_TX_Ready=1.
REQ-014 o_TX_Ready  output  1  high when no response byte is pending.
REQ-015 o_Frame_Err  output  1  one-cycle pulse: frame aborted (CS_n rose with 1..RX_WIDTH-1 bits received).
REQ-016 o_Overrun  output  1  one-cycle pulse: SCK rising edge seen after RX_WIDTH bits within same CS_n low period.

Function
REQ-017 i_SPI_Clk, i_SPI_CS_n, i_SPI_MOSI shall each pass a 2-flop synchronizer; a third register shall provide edge detection.
REQ-018 Correct operation requires i_Clk frequency >= 4x SCK frequency; no behaviour defined below that.
REQ-019 FSM states: IDLE, SHIFT, HOLD.
REQ-020 IDLE -> SHIFT on synchronized CS_n falling edge; bit counter cleared; TX shift register loaded from pending byte (or all zeros if none pending); pending flag cleared.
REQ-021 SHIFT: each synchronized SCK rising edge shifts synchronized MOSI into RX shift register LSB, increments bit counter.
REQ-022 SHIFT: each synchronized SCK falling edge shifts TX register left one bit; o_SPI_MISO = TX register MSB; after TX_WIDTH bits, o_SPI_MISO = 0.
REQ-023 On RX_WIDTH-th rising edge: o_RX_Word <= shift register contents, o_RX_DV pulses next cycle, FSM -> HOLD; DV within 4 i_Clk cycles of the physical SCK edge.
REQ-024 HOLD: further SCK rising edges pulse o_Overrun once per edge, do not alter o_RX_Word; MISO = 0.
REQ-025 SHIFT or HOLD -> IDLE on synchronized CS_n rising edge; if in SHIFT with counter > 0, pulse o_Frame_Err; if counter = 0, no pulse.
REQ-026 Aborted frame shall not update o_RX_Word nor pulse o_RX_DV.
REQ-027 o_TX_Ready = 1 iff no byte pending; i_TX_DV with o_TX_Ready=1 latches i_TX_Byte and drops o_TX_Ready next cycle; i_TX_DV with o_TX_Ready=0 ignored.
REQ-028 A byte loaded during SHIFT/HOLD shall be used in the next frame, not the current one.
REQ-029 i_TX_DV in the same cycle as frame-start load: frame uses previously pending byte (or zeros); new byte becomes pending only if o_TX_Ready was 1.
REQ-030 Simultaneous CS_n rising edge and final SCK rising edge: complete frame wins (DV pulse, no Frame_Err).
REQ-031 o_SPI_MISO_En = 1 in SHIFT and HOLD, 0 in IDLE.

Reset
REQ-032 While i_Rst_L=0: FSM IDLE, counters and shift registers 0, o_RX_Word=0, o_RX_DV=0, o_Frame_Err=0, o_Overrun=0, o_SPI_MISO=0, o_SPI_MISO_En=0, o_TX_Ready=1, pending byte discarded.
REQ-033 Reset mid-frame: frame discarded without any pulse; after release, block waits for a fresh CS_n falling edge (CS_n already low shall not start a frame).

Verification
REQ-034 Load 8'hA5, send frame 16'hC1A2 -> o_RX_Word=16'hC1A2 with single o_RX_DV pulse; MISO bits 1010_0101 then 8 zeros; o_TX_Ready returns 1 at frame start.
REQ-035 Back-to-back frames 16'hC1A2 then 16'hC1A3, no byte loaded -> two DV pulses, words in order, MISO all zeros.
REQ-036 CS_n deasserted after 7 SCK cycles -> one o_Frame_Err pulse, o_RX_Word unchanged, no DV.
REQ-037 17 SCK cycles in one frame, data 16'h1234 then 1 -> DV with 16'h1234, one o_Overrun pulse.
REQ-038 i_Rst_L low after 9 bits of 16'hC1A2, released with CS_n still low, then CS_n high/low and full 16'hC1A3 -> no pulses from aborted frame, o_RX_Word=16'hC1A3.
REQ-039 i_TX_DV 8'h3C then 8'hFF while o_TX_Ready=0 -> next frame transmits 8'h3C.
